vec_cache_4ton_rsp_xbar: RTL and testbench

VEC_CACHE_4TON_RSP_XBAR -- requirements
Module: vec_cache_4ton_rsp_xbar

---
 rtl/vec_cache_4ton_rsp_xbar.sv | 131 +++++++++++++
 tb/tb_vec_cache_4ton_rsp_xbar.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_cache_4ton_rsp_xbar.sv
// Response crossbar: four cache-side sources, each with a 2-deep FIFO, feeding N
// requester-side output registers with independent per-destination round-robin arbiters.
module vec_cache_4ton_rsp_xbar #(
   parameter  int N         = 8,
   parameter  int PLD_WIDTH = 32,
   localparam int DW        = $clog2(N)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [3:0]                    in_vld,
   input  logic [3:0][PLD_WIDTH-1:0]     in_pld,
   input  logic [3:0][DW-1:0]            in_dest,
   output logic [3:0]                    in_rdy,
   output logic [N-1:0]                  out_vld,
   output logic [N-1:0][PLD_WIDTH-1:0]   out_pld,
   input  logic [N-1:0]                  out_rdy,
   output logic                          err_dest
);

   typedef struct packed {
      logic [PLD_WIDTH-1:0] pld;
      logic [DW-1:0]        dest;
   } entry_t;

   entry_t                       mem_q [4][2];
   logic [3:0][1:0]              cnt_q;
   logic [3:0]                   wr_ptr_q;
   logic [3:0]                   rd_ptr_q;
   entry_t [3:0]                 head;
   logic [3:0]                   push;
   logic [3:0]                   pop;
   logic [3:0]                   bad_dest;

   logic [N-1:0][1:0]            rr_ptr_q;
   logic [N-1:0]                 out_vld_q;
   logic [N-1:0][PLD_WIDTH-1:0]  out_pld_q;
   logic                         err_q;

   logic [N-1:0]                 gnt_vld;
   logic [N-1:0]                 gnt;
   logic [N-1:0][1:0]            gnt_src;
   logic [1:0]                   scan_idx;

   for (genvar j = 0; j < 4; j++) begin : g_src
      assign head[j]   = mem_q[j][rd_ptr_q[j]];
      assign in_rdy[j] = (cnt_q[j] != 2'd2);
      assign push[j]   = in_vld[j] & in_rdy[j];

      // Out-of-range indices are only encodable when N is not a power of two.
      if ((1 << DW) == N) begin : g_pow2
         assign bad_dest[j] = 1'b0;
      end else begin : g_npow2
         localparam logic [DW:0] N_LIM = (DW+1)'(N);
         assign bad_dest[j] = (cnt_q[j] != 2'd0) && ({1'b0, head[j].dest} >= N_LIM);
      end
   end

   // A source's head names exactly one destination, so at most one arbiter can pop it.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      gnt_vld  = '0;
      gnt      = '0;
      gnt_src  = '0;
      scan_idx = '0;
      pop      = bad_dest;
      for (int d = 0; d < N; d++) begin
         for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr_q[d] + 2'(k);
            if (!gnt_vld[d] && (cnt_q[scan_idx] != 2'd0) && (head[scan_idx].dest == DW'(d))) begin
               gnt_vld[d] = 1'b1;
               gnt_src[d] = scan_idx;
            end
         end
         if (gnt_vld[d] && (!out_vld_q[d] || out_rdy[d])) begin
            gnt[d]          = 1'b1;
            pop[gnt_src[d]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         for (int j = 0; j < 4; j++) begin
            if (push[j]) wr_ptr_q[j] <= ~wr_ptr_q[j];
            if (pop[j])  rd_ptr_q[j] <= ~rd_ptr_q[j];
            case ({push[j], pop[j]})
               2'b10:   cnt_q[j] <= cnt_q[j] + 2'd1;
               2'b01:   cnt_q[j] <= cnt_q[j] - 2'd1;
               default: cnt_q[j] <= cnt_q[j];
            endcase
         end
      end
   end

   // NOTE: FIFO storage has no reset; occupancy is tracked by the reset pointers and counts.
   always_ff @(posedge clk) begin
      for (int j = 0; j < 4; j++) begin
         if (push[j]) mem_q[j][wr_ptr_q[j]] <= {in_pld[j], in_dest[j]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q <= '0;
         out_pld_q <= '0;
         rr_ptr_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         for (int d = 0; d < N; d++) begin
            if (gnt[d]) begin
               out_vld_q[d] <= 1'b1;
               out_pld_q[d] <= head[gnt_src[d]].pld;
               rr_ptr_q[d]  <= gnt_src[d] + 2'd1;
            end else if (out_rdy[d]) begin
               out_vld_q[d] <= 1'b0;
            end
         end
         err_q <= err_q | (|bad_dest);
      end
   end

   assign out_vld  = out_vld_q;
   assign out_pld  = out_pld_q;
   assign err_dest = err_q;

endmodule

// File: tb/tb_vec_cache_4ton_rsp_xbar.sv
// Self-checking bench: directed cycle table, multi-cycle corner sequences, and a
// randomized run scored against per-(source,destination) ordered queues.
module tb_vec_cache_4ton_rsp_xbar;

   logic clk;
   logic rst_n;

   logic [3:0]        in_vld;
   logic [3:0][31:0]  in_pld;
   logic [3:0][2:0]   in_dest;
   logic [3:0]        in_rdy;
   logic [7:0]        out_vld;
   logic [7:0][31:0]  out_pld;
   logic [7:0]        out_rdy;
   logic              err_dest;

   logic [3:0]        in_vld6;
   logic [3:0][31:0]  in_pld6;
   logic [3:0][2:0]   in_dest6;
   logic [3:0]        in_rdy6;
   logic [5:0]        out_vld6;
   logic [5:0][31:0]  out_pld6;
   logic [5:0]        out_rdy6;
   logic              err_dest6;

   vec_cache_4ton_rsp_xbar #(.N(8), .PLD_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_vld(in_vld), .in_pld(in_pld), .in_dest(in_dest), .in_rdy(in_rdy),
      .out_vld(out_vld), .out_pld(out_pld), .out_rdy(out_rdy), .err_dest(err_dest)
   );

   vec_cache_4ton_rsp_xbar #(.N(6), .PLD_WIDTH(32)) dut6 (
      .clk(clk), .rst_n(rst_n),
      .in_vld(in_vld6), .in_pld(in_pld6), .in_dest(in_dest6), .in_rdy(in_rdy6),
      .out_vld(out_vld6), .out_pld(out_pld6), .out_rdy(out_rdy6), .err_dest(err_dest6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      string            name;
      logic [3:0]       vld;
      logic [3:0][2:0]  dest;
      logic [3:0][31:0] pld;
      logic [7:0]       e_ovld;
      int               cd;
      logic [31:0]      e_pld;
   } vec_t;

   function automatic vec_t mk(input string nm, input logic [3:0] vld, input logic [11:0] dest,
                               input logic [31:0] p3, input logic [31:0] p2,
                               input logic [31:0] p1, input logic [31:0] p0,
                               input logic [7:0] eov, input int cd, input logic [31:0] ep);
      vec_t v;
      v.name = nm; v.vld = vld; v.dest = dest; v.pld = {p3, p2, p1, p0};
      v.e_ovld = eov; v.cd = cd; v.e_pld = ep;
      return v;
   endfunction

   // Reference model: expected in-order payloads per (source, destination) pair.
   logic [31:0] sbq [4][8][$];
   logic [7:0]        prev_stall;
   logic [7:0][31:0]  prev_pld;

   task automatic observe();
      for (int j = 0; j < 4; j++)
         if (in_vld[j] && in_rdy[j]) sbq[j][in_dest[j]].push_back(in_pld[j]);
      for (int d = 0; d < 8; d++) begin
         if (out_vld[d] && out_rdy[d]) begin
            int s;
            s = int'(out_pld[d][25:24]);
            check("rnd_dest", 64'(out_pld[d][23:16]), 64'(d));
            check("rnd_avail", 64'(sbq[s][d].size() > 0), 64'd1);
            if (sbq[s][d].size() > 0) begin
               check("rnd_pld", 64'(out_pld[d]), 64'(sbq[s][d][0]));
               void'(sbq[s][d].pop_front());
            end
         end
      end
      prev_stall = out_vld & ~out_rdy;
      prev_pld   = out_pld;
   endtask

   task automatic hold_check();
      for (int d = 0; d < 8; d++) begin
         if (prev_stall[d]) begin
            check("rnd_hold_vld", 64'(out_vld[d]), 64'd1);
            check("rnd_hold_pld", 64'(out_pld[d]), 64'(prev_pld[d]));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[$];
   logic [31:0] got[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      in_vld = '0; in_pld = '0; in_dest = '0; out_rdy = 8'hFF;
      in_vld6 = '0; in_pld6 = '0; in_dest6 = '0; out_rdy6 = 6'h3F;
      prev_stall = '0; prev_pld = '0;

      // Directed cycle table: inputs for one cycle, outputs expected after the edge.
      vecs.push_back(mk("single_push", 4'b0100, 12'o0500, 0, 32'hA5A5_0001, 0, 0, 8'h00, 5, 0));
      vecs.push_back(mk("single_out",  4'b0000, 12'o0000, 0, 0, 0, 0, 8'h20, 5, 32'hA5A5_0001));
      vecs.push_back(mk("single_gone", 4'b0000, 12'o0000, 0, 0, 0, 0, 8'h00, 5, 32'hA5A5_0001));
      vecs.push_back(mk("cont_push", 4'hF, 12'o3333, 32'h3000_0003, 32'h3000_0002,
                        32'h3000_0001, 32'h3000_0000, 8'h00, 3, 0));
      vecs.push_back(mk("cont_s0",   4'h0, 12'o0, 0, 0, 0, 0, 8'h08, 3, 32'h3000_0000));
      vecs.push_back(mk("cont_s1",   4'h0, 12'o0, 0, 0, 0, 0, 8'h08, 3, 32'h3000_0001));
      vecs.push_back(mk("cont_s2",   4'h0, 12'o0, 0, 0, 0, 0, 8'h08, 3, 32'h3000_0002));
      vecs.push_back(mk("cont_s3",   4'h0, 12'o0, 0, 0, 0, 0, 8'h08, 3, 32'h3000_0003));
      vecs.push_back(mk("cont_idle", 4'h0, 12'o0, 0, 0, 0, 0, 8'h00, 3, 32'h3000_0003));
      vecs.push_back(mk("rr1_push", 4'b0010, 12'o0030, 0, 0, 32'h3100_0001, 0, 8'h00, 3, 32'h3000_0003));
      vecs.push_back(mk("rr1_out",  4'b0000, 12'o0, 0, 0, 0, 0, 8'h08, 3, 32'h3100_0001));
      vecs.push_back(mk("rr1_idle", 4'b0000, 12'o0, 0, 0, 0, 0, 8'h00, 3, 32'h3100_0001));
      vecs.push_back(mk("rr2_push", 4'b0101, 12'o0303, 0, 32'h3200_0002, 0, 32'h3200_0000,
                        8'h00, 3, 32'h3100_0001));
      vecs.push_back(mk("rr2_s2",   4'b0000, 12'o0, 0, 0, 0, 0, 8'h08, 3, 32'h3200_0002));
      vecs.push_back(mk("rr2_s0",   4'b0000, 12'o0, 0, 0, 0, 0, 8'h08, 3, 32'h3200_0000));
      vecs.push_back(mk("rr2_idle", 4'b0000, 12'o0, 0, 0, 0, 0, 8'h00, 3, 32'h3200_0000));
      for (int k = 0; k < 4; k++) begin
         logic [31:0] b;
         b = 32'h4000_0000 + 32'(k * 16);
         vecs.push_back(mk("par", 4'hF, 12'o3210, b + 3, b + 2, b + 1, b,
                           (k == 0) ? 8'h00 : 8'h0F, 0,
                           (k == 0) ? 32'h0 : 32'h4000_0000 + 32'((k - 1) * 16)));
      end
      vecs.push_back(mk("par_tail", 4'h0, 12'o0, 0, 0, 0, 0, 8'h0F, 0, 32'h4000_0030));
      vecs.push_back(mk("par_idle", 4'h0, 12'o0, 0, 0, 0, 0, 8'h00, 0, 32'h4000_0030));

      // Reset state.
      #12;
      check("rst_in_rdy", 64'(in_rdy), 64'hF);
      check("rst_out_vld", 64'(out_vld), 64'h0);
      check("rst_err", 64'(err_dest), 64'h0);
      check("rst_pld5", 64'(out_pld[5]), 64'h0);
      check("rst_in_rdy6", 64'(in_rdy6), 64'hF);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) begin
         in_vld = vecs[i].vld; in_dest = vecs[i].dest; in_pld = vecs[i].pld; out_rdy = 8'hFF;
         tick();
         check({vecs[i].name, "_ovld"}, 64'(out_vld), 64'(vecs[i].e_ovld));
         check({vecs[i].name, "_irdy"}, 64'(in_rdy), 64'hF);
         check({vecs[i].name, "_pld"}, 64'(out_pld[vecs[i].cd]), 64'(vecs[i].e_pld));
      end
      check("table_err", 64'(err_dest), 64'h0);

      // Backpressure on destination 1 from source 0.
      out_rdy = 8'hFD;
      for (int k = 0; k < 3; k++) begin
         in_vld = 4'b0001; in_dest = '0; in_dest[0] = 3'd1; in_pld = '0;
         in_pld[0] = 32'h5000_0000 + 32'(k);
         check("bp_accept_rdy", 64'(in_rdy[0]), 64'd1);
         tick();
      end
      in_vld = '0;
      check("bp_full_rdy", 64'(in_rdy), 64'hE);
      check("bp_full_vld", 64'(out_vld[1]), 64'd1);
      check("bp_full_pld", 64'(out_pld[1]), 64'h5000_0000);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("bp_hold_pld", 64'(out_pld[1]), 64'h5000_0000);
         check("bp_hold_vld", 64'(out_vld[1]), 64'd1);
         check("bp_hold_rdy", 64'(in_rdy[0]), 64'd0);
      end
      out_rdy = 8'hFF;
      got.delete();
      for (int c = 0; c < 10; c++) begin
         if (out_vld[1]) got.push_back(out_pld[1]);
         tick();
      end
      check("bp_drain_count", 64'(got.size()), 64'd3);
      for (int k = 0; k < 3; k++)
         if (k < got.size()) check("bp_drain_order", 64'(got[k]), 64'h5000_0000 + 64'(k));

      // Out-of-range destination on the N=6 instance, followed by a legal entry.
      check("err6_init", 64'(err_dest6), 64'd0);
      in_vld6 = 4'b0001; in_dest6[0] = 3'd7; in_pld6[0] = 32'hDEAD_0007;
      tick();
      check("err6_t0_err", 64'(err_dest6), 64'd0);
      check("err6_t0_vld", 64'(out_vld6), 64'h0);
      in_dest6[0] = 3'd2; in_pld6[0] = 32'h6000_0002;
      tick();
      in_vld6 = '0;
      check("err6_t1_err", 64'(err_dest6), 64'd1);
      check("err6_t1_vld", 64'(out_vld6), 64'h0);
      tick();
      check("err6_t2_vld", 64'(out_vld6), 64'h04);
      check("err6_t2_pld", 64'(out_pld6[2]), 64'h6000_0002);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("err6_sticky", 64'(err_dest6), 64'd1);
         check("err6_no_out", 64'(out_vld6), 64'h0);
      end

      // Reset with full FIFOs and valid outputs.
      out_rdy = 8'h00;
      in_vld = 4'hF; in_dest = 12'o3210;
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 4; j++) in_pld[j] = 32'h7000_0000 + 32'(k * 16 + j);
         tick();
      end
      in_vld = '0;
      check("rstmid_pre_rdy", 64'(in_rdy), 64'h0);
      check("rstmid_pre_vld", 64'(out_vld), 64'h0F);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_vld", 64'(out_vld), 64'h0);
      check("rstmid_rdy", 64'(in_rdy), 64'hF);
      check("rstmid_err6", 64'(err_dest6), 64'd0);
      check("rstmid_pld0", 64'(out_pld[0]), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      out_rdy = 8'hFF;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rstmid_quiet", 64'(out_vld), 64'h0);
         check("rstmid_quiet6", 64'(out_vld6), 64'h0);
      end

      // Randomized traffic against the ordered scoreboard.
      prev_stall = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         hold_check();
         in_vld = 4'($urandom);
         for (int j = 0; j < 4; j++) begin
            in_dest[j] = 3'($urandom_range(0, 7));
            in_pld[j]  = {8'(j), 8'(in_dest[j]), 16'(cyc)};
         end
         out_rdy = 8'($urandom) | 8'($urandom);
         #1;
         observe();
         @(posedge clk);
         #1;
      end
      in_vld = '0;
      out_rdy = 8'hFF;
      for (int cyc = 0; cyc < 20; cyc++) begin
         hold_check();
         #1;
         observe();
         @(posedge clk);
         #1;
      end
      begin
         int left;
         left = 0;
         for (int s = 0; s < 4; s++)
            for (int d = 0; d < 8; d++) left += sbq[s][d].size();
         check("drain_empty", 64'(left), 64'd0);
      end
      check("drain_rdy", 64'(in_rdy), 64'hF);
      check("drain_vld", 64'(out_vld), 64'h0);
      check("drain_err", 64'(err_dest), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
